mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StWait} arb_state_e;

    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    localparam int unsigned DefAddrW      = 32;
    localparam int unsigned DefDataW      = 32;
    localparam int unsigned DefMaxDstreak = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Owner selection between fetch and data requesters, with a data-streak limiter
// so a waiting fetch is not starved by back-to-back data traffic.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = DefMaxDstreak
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   if_gnt,
    input  logic   dm_gnt,
    output owner_e owner
);

    localparam int unsigned CntW = $clog2(MAX_DSTREAK + 2);
    localparam logic [CntW-1:0] StreakMax = CntW'(MAX_DSTREAK);

    logic [CntW-1:0] streak_q, streak_d;

    assign owner = (dm_req && !(if_req && (streak_q == StreakMax))) ? OWN_DM : OWN_IF;

    always_comb begin
        streak_d = streak_q;
        if (if_gnt) begin
            streak_d = '0;
        end else if (dm_gnt) begin
            // Only count data grants that actually made a fetch wait.
            if (!if_req) begin
                streak_d = '0;
            end else if (streak_q != StreakMax) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses, one
// transaction in flight, request fields registered onto the memory side.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned MAX_DSTREAK = DefMaxDstreak
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              pick_owner;
    logic                drop_q, drop_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                accept, respond;

    mem_arb_pick #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .dm_req (dm_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt),
        .owner  (pick_owner)
    );

    assign accept  = (state_q == StReq) && mem_gnt;
    assign respond = (state_q == StWait) && mem_rvalid;

    assign if_gnt    = accept && (owner_q == OWN_IF);
    assign dm_gnt    = accept && (owner_q == OWN_DM);
    // A flush landing in the response cycle itself also discards the data.
    assign if_rvalid = respond && (owner_q == OWN_IF) && !drop_q && !if_flush;
    assign dm_rvalid = respond && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if ((state_q != StIdle) && (owner_q == OWN_IF) && if_flush) begin
            drop_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (if_req || dm_req) begin
                    state_d   = StReq;
                    owner_d   = pick_owner;
                    mem_req_d = 1'b1;
                    if (pick_owner == OWN_DM) begin
                        mem_we_d    = dm_we;
                        mem_be_d    = dm_be;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d   = StWait;
                    mem_req_d = 1'b0;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= OWN_IF;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MaxD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_DSTREAK (MaxD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        if_req;  logic [31:0] if_addr; logic if_flush;
        logic        dm_req;  logic dm_we; logic [3:0] dm_be;
        logic [31:0] dm_addr; logic [31:0] dm_wdata;
        logic        gnt;     logic rvalid; logic [31:0] rdata;
        logic        e_req;   logic e_dat; logic e_we; logic [3:0] e_be;
        logic [31:0] e_addr;  logic [31:0] e_wdata;
        logic        e_ig;    logic e_dg; logic e_irv; logic e_drv; logic e_rd;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 0);
        chk({tag, "_mem_we"}, 64'(mem_we), 0);
        chk({tag, "_mem_be"}, 64'(mem_be), 0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
        chk({tag, "_gnts"}, 64'({if_gnt, dm_gnt}), 0);
        chk({tag, "_rvalids"}, 64'({if_rvalid, dm_rvalid}), 0);
        chk({tag, "_rdata"}, 64'({if_rdata, dm_rdata}), 0);
    endtask

    // Outputs must read zero while held in reset even with every input active.
    task automatic do_reset();
        clr_in();
        if_req = 1; dm_req = 1; mem_gnt = 1; mem_rvalid = 1; mem_rdata = '1;
        rst = 0;
        #1 chk_zero("reset_a");
        @(negedge clk);
        #1 chk_zero("reset_b");
        @(negedge clk);
        clr_in();
        rst = 1;
    endtask

    // Transaction-level reference model state.
    bit          m_busy, m_acc, m_own_dm, m_drop, m_we;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          ip, dp, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    bit          e_req, e_ig, e_dg, e_irv, e_drv;
    int          seq[$];
    int          exp_seq[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clr_in();
        //          if        flush dm we be    addr    wdata        g rv rdata
        //          req mdat we be   addr   wdata   ig dg irv drv rd
        vt[0]  = '{1,'h100,0, 0,0,0,0,0,                   0,0,0,
                   0,0,0,0,0,0,                            0,0,0,0,0};
        vt[1]  = '{1,'h100,0, 0,0,0,0,0,                   1,0,0,
                   1,0,0,0,'h100,0,                        1,0,0,0,0};
        vt[2]  = '{0,0,0,     0,0,0,0,0,                   0,1,'hDEADBEEF,
                   0,0,0,0,0,0,                            0,0,1,0,1};
        vt[3]  = '{0,0,0,     0,0,0,0,0,                   0,0,0,
                   0,0,0,0,0,0,                            0,0,0,0,0};
        vt[4]  = '{1,'h300,0, 1,1,'hF,'h200,'h12345678,    0,0,0,
                   0,0,0,0,0,0,                            0,0,0,0,0};
        vt[5]  = '{1,'h300,0, 1,1,'hF,'h200,'h12345678,    1,0,0,
                   1,1,1,'hF,'h200,'h12345678,             0,1,0,0,0};
        vt[6]  = '{1,'h300,0, 0,0,0,0,0,                   0,1,'h0BADF00D,
                   0,0,0,0,0,0,                            0,0,0,1,0};
        vt[7]  = '{1,'h300,0, 0,0,0,0,0,                   0,0,0,
                   0,0,0,0,0,0,                            0,0,0,0,0};
        vt[8]  = '{1,'h300,0, 0,0,0,0,0,                   1,0,0,
                   1,0,0,0,'h300,0,                        1,0,0,0,0};
        vt[9]  = '{0,0,0,     0,0,0,0,0,                   0,1,'hCAFEF00D,
                   0,0,0,0,0,0,                            0,0,1,0,1};
        vt[10] = '{0,0,0,     0,0,0,0,0,                   0,1,'h11111111,
                   0,0,0,0,0,0,                            0,0,0,0,0};
        vt[11] = '{0,0,0,     1,0,'h3,'h40,0,              0,0,0,
                   0,0,0,0,0,0,                            0,0,0,0,0};
        vt[12] = '{0,0,0,     1,0,'h3,'h40,0,              0,1,'h22222222,
                   1,1,0,'h3,'h40,0,                       0,0,0,0,0};
        vt[13] = '{0,0,0,     1,0,'h3,'h40,0,              1,0,0,
                   1,1,0,'h3,'h40,0,                       0,1,0,0,0};
        vt[14] = '{0,0,0,     0,0,0,0,0,                   0,1,'h55AA55AA,
                   0,0,0,0,0,0,                            0,0,0,1,1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            if_req = vt[i].if_req; if_addr = vt[i].if_addr; if_flush = vt[i].if_flush;
            dm_req = vt[i].dm_req; dm_we = vt[i].dm_we; dm_be = vt[i].dm_be;
            dm_addr = vt[i].dm_addr; dm_wdata = vt[i].dm_wdata;
            mem_gnt = vt[i].gnt; mem_rvalid = vt[i].rvalid; mem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("vec%0d_mem_req", i), 64'(mem_req), 64'(vt[i].e_req));
            chk($sformatf("vec%0d_if_gnt", i), 64'(if_gnt), 64'(vt[i].e_ig));
            chk($sformatf("vec%0d_dm_gnt", i), 64'(dm_gnt), 64'(vt[i].e_dg));
            chk($sformatf("vec%0d_if_rvalid", i), 64'(if_rvalid), 64'(vt[i].e_irv));
            chk($sformatf("vec%0d_dm_rvalid", i), 64'(dm_rvalid), 64'(vt[i].e_drv));
            if (vt[i].e_req) begin
                chk($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'(vt[i].e_addr));
                chk($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vt[i].e_we));
                if (vt[i].e_dat) begin
                    chk($sformatf("vec%0d_mem_be", i), 64'(mem_be), 64'(vt[i].e_be));
                    chk($sformatf("vec%0d_mem_wdata", i), 64'(mem_wdata), 64'(vt[i].e_wdata));
                end
            end
            if (vt[i].e_rd && vt[i].e_irv) chk($sformatf("vec%0d_if_rdata", i), 64'(if_rdata),
                                               64'(vt[i].rdata));
            if (vt[i].e_rd && vt[i].e_drv) chk($sformatf("vec%0d_dm_rdata", i), 64'(dm_rdata),
                                               64'(vt[i].rdata));
        end

        // Data hammering with a fetch waiting: four data grants, then the fetch.
        @(negedge clk);
        do_reset();
        dm_req = 1; dm_addr = 'h400; dm_be = 'hF;
        if_req = 1; if_addr = 'h500;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 'h9;
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        seq.delete();
        for (int c = 0; c < 60 && seq.size() < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (if_gnt && dm_gnt) chk("streak_both_gnt", 1, 0);
            if (dm_gnt) seq.push_back(1);
            else if (if_gnt) seq.push_back(0);
        end
        chk("streak_grant_count", 64'(seq.size()), 10);
        for (int k = 0; k < seq.size() && k < 10; k++) begin
            chk($sformatf("streak_grant%0d_is_dm", k), 64'(seq[k]), 64'(exp_seq[k]));
        end

        // Memory stalls accept for five cycles; request must hold steady.
        @(negedge clk);
        do_reset();
        dm_req = 1; dm_addr = 'h44; dm_be = 'h2; dm_wdata = 'hA5;
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if_req = 1; if_addr = 'h999;
            #1;
            chk($sformatf("stall%0d_mem_req", c), 64'(mem_req), 1);
            chk($sformatf("stall%0d_mem_addr", c), 64'(mem_addr), 'h44);
            chk($sformatf("stall%0d_mem_be", c), 64'(mem_be), 'h2);
            chk($sformatf("stall%0d_gnts", c), 64'({if_gnt, dm_gnt}), 0);
        end
        @(negedge clk); mem_gnt = 1;
        #1 chk("stall_accept_dm_gnt", 64'({if_gnt, dm_gnt}), 1);
        @(negedge clk); dm_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 'h77;
        #1 chk("stall_dm_rvalid", 64'(dm_rvalid), 1);
        chk("stall_dm_rdata", 64'(dm_rdata), 'h77);
        chk("stall_if_rvalid", 64'(if_rvalid), 0);

        // Fetch flushed while waiting for its response.
        @(negedge clk); clr_in(); if_req = 1; if_addr = 'h180;
        @(negedge clk); mem_gnt = 1;
        #1 chk("flush_if_gnt", 64'(if_gnt), 1);
        @(negedge clk); if_req = 0; mem_gnt = 0; if_flush = 1;
        #1 chk("flush_wait_if_rvalid", 64'(if_rvalid), 0);
        @(negedge clk); if_flush = 0; mem_rvalid = 1; mem_rdata = 'hBAD;
        #1 chk("flush_resp_if_rvalid", 64'(if_rvalid), 0);
        @(negedge clk); mem_rvalid = 0; dm_req = 1; dm_we = 1; dm_be = 'hF; dm_addr = 'h600;
        @(negedge clk); mem_gnt = 1; if_flush = 1;
        #1 chk("flush_next_mem_req", 64'(mem_req), 1);
        chk("flush_next_mem_addr", 64'(mem_addr), 'h600);
        chk("flush_next_dm_gnt", 64'(dm_gnt), 1);
        @(negedge clk); dm_req = 0; mem_gnt = 0; mem_rvalid = 1;
        #1 chk("flush_dm_owner_dm_rvalid", 64'(dm_rvalid), 1);
        @(negedge clk); clr_in(); if_req = 1; if_addr = 'h184;
        @(negedge clk); mem_gnt = 1;
        #1 chk("flush_after_if_gnt", 64'(if_gnt), 1);
        @(negedge clk); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 'h1234;
        #1 chk("flush_after_if_rvalid", 64'(if_rvalid), 1);
        chk("flush_after_if_rdata", 64'(if_rdata), 'h1234);

        // Reset lands during WAIT; the late response must vanish.
        @(negedge clk); clr_in(); if_req = 1; if_addr = 'h1C0;
        @(negedge clk); mem_gnt = 1;
        @(negedge clk); if_req = 0; mem_gnt = 0;
        #2 rst = 0;
        #1 chk_zero("midrst");
        @(negedge clk); rst = 1; mem_rvalid = 1; mem_rdata = 'hFEED;
        #1 chk("midrst_late_rvalids", 64'({if_rvalid, dm_rvalid}), 0);
        chk("midrst_late_mem_req", 64'(mem_req), 0);
        @(negedge clk); mem_rvalid = 0; dm_req = 1; dm_addr = 'h700;
        @(negedge clk); mem_gnt = 1;
        #1 chk("midrst_new_mem_req", 64'(mem_req), 1);
        chk("midrst_new_mem_addr", 64'(mem_addr), 'h700);
        chk("midrst_new_dm_gnt", 64'(dm_gnt), 1);

        // Randomized traffic against the reference model.
        @(negedge clk);
        do_reset();
        m_busy = 0; m_acc = 0; m_own_dm = 0; m_drop = 0; m_streak = 0;
        m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0;
        ip = 0; dp = 0; ia = 0; da = 0; dwe = 0; dbe = 0; dwd = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!ip && ($urandom_range(1, 0) == 1)) begin
                ip = 1; ia = $urandom;
            end
            if (!dp && ($urandom_range(3, 0) != 0)) begin
                dp = 1; da = $urandom; dwe = 1'($urandom_range(1, 0));
                dbe = 4'($urandom); dwd = $urandom;
            end
            if_req = ip; if_addr = ia;
            dm_req = dp; dm_addr = da; dm_we = dwe; dm_be = dbe; dm_wdata = dwd;
            mem_gnt = 1'($urandom_range(1, 0));
            mem_rvalid = 1'($urandom_range(1, 0));
            mem_rdata = $urandom;
            if_flush = ($urandom_range(7, 0) == 0);
            #1;
            e_req = m_busy && !m_acc;
            e_ig  = e_req && !m_own_dm && mem_gnt;
            e_dg  = e_req && m_own_dm && mem_gnt;
            e_irv = m_busy && m_acc && mem_rvalid && !m_own_dm && !m_drop && !if_flush;
            e_drv = m_busy && m_acc && mem_rvalid && m_own_dm;
            chk("rnd_mem_req", 64'(mem_req), 64'(e_req));
            chk("rnd_if_gnt", 64'(if_gnt), 64'(e_ig));
            chk("rnd_dm_gnt", 64'(dm_gnt), 64'(e_dg));
            chk("rnd_if_rvalid", 64'(if_rvalid), 64'(e_irv));
            chk("rnd_dm_rvalid", 64'(dm_rvalid), 64'(e_drv));
            if (e_req) begin
                chk("rnd_mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("rnd_mem_we", 64'(mem_we), 64'(m_we));
                if (m_own_dm) begin
                    chk("rnd_mem_be", 64'(mem_be), 64'(m_be));
                    chk("rnd_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                end
            end
            if (e_irv) chk("rnd_if_rdata", 64'(if_rdata), 64'(mem_rdata));
            if (e_drv && !m_we) chk("rnd_dm_rdata", 64'(dm_rdata), 64'(mem_rdata));

            if (m_busy && !m_own_dm && if_flush) m_drop = 1;
            if (!m_busy) begin
                if (if_req || dm_req) begin
                    m_busy = 1; m_acc = 0; m_drop = 0;
                    m_own_dm = dm_req && !(if_req && (m_streak == MaxD));
                    if (m_own_dm) begin
                        m_addr = dm_addr; m_we = dm_we; m_be = dm_be; m_wdata = dm_wdata;
                    end else begin
                        m_addr = if_addr; m_we = 0;
                    end
                end
            end else if (!m_acc) begin
                if (mem_gnt) begin
                    m_acc = 1;
                    if (!m_own_dm) m_streak = 0;
                    else if (!if_req) m_streak = 0;
                    else if (m_streak < MaxD) m_streak = m_streak + 1;
                end
            end else if (mem_rvalid) begin
                m_busy = 0;
            end
            if (e_ig) ip = 0;
            if (e_dg) dp = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
